// File: rtl/two_way_karatsuba_iter.sv
// Iterative two-way Karatsuba multiplier over GF(2)[x].
// Three digit-serial shift-and-XOR sub-multipliers, a combine step, output pipe.
module two_way_karatsuba_iter #(
  parameter int N     = 283,
  parameter int DIGIT = 1,
  parameter int PIPE  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           ready,
  output logic           valid,
  output logic [2*N-1:0] c
);

  localparam int L  = N / 2;
  localparam int H  = N - L;
  localparam int K  = (H + DIGIT - 1) / DIGIT;
  localparam int PW = 2 * H - 1;
  localparam int W  = 2 * N;
  localparam int CW = $clog2(K + 1);
  localparam logic [CW-1:0] KL = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    COMB
  } state_t;

  state_t        state;
  logic [H-1:0]  am, bm, sm;
  logic [PW-1:0] cm, dm, tm;
  logic [PW-1:0] p0, p1, p2;
  logic [PW-1:0] p0_n, p1_n, p2_n;
  logic [CW-1:0] cnt;
  logic [W-1:0]  r;
  logic          ld;
  logic [W-1:0]  pd [0:PIPE];
  logic          pv [0:PIPE];

  logic [H-1:0]  a_hi, a_lo, b_hi, b_lo;

  assign a_hi = a[N-1:L];
  assign a_lo = H'(a[L-1:0]);
  assign b_hi = b[N-1:L];
  assign b_lo = H'(b[L-1:0]);

  // Multiplier bits shift out to the right, multiplicands shift left,
  // so digit j of this cycle always sits at bit j.
  always_comb begin
    p0_n = p0;
    p1_n = p1;
    p2_n = p2;
    for (int j = 0; j < DIGIT; j++) begin
      if (am[j]) p0_n = p0_n ^ (cm << j);
      if (bm[j]) p1_n = p1_n ^ (dm << j);
      if (sm[j]) p2_n = p2_n ^ (tm << j);
    end
  end

  // Karatsuba recombination; middle term needs no subtraction in GF(2).
  always_comb begin
    r = (W'(p0) << (2 * L))
      ^ (W'(p0 ^ p1 ^ p2) << L)
      ^ W'(p1);
  end

  assign ld = (state == COMB);

  // Control FSM with operand latching and digit-serial accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      am    <= '0;
      bm    <= '0;
      sm    <= '0;
      cm    <= '0;
      dm    <= '0;
      tm    <= '0;
      p0    <= '0;
      p1    <= '0;
      p2    <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            am    <= a_hi;
            bm    <= a_lo;
            sm    <= a_hi ^ a_lo;
            cm    <= PW'(b_hi);
            dm    <= PW'(b_lo);
            tm    <= PW'(b_hi ^ b_lo);
            p0    <= '0;
            p1    <= '0;
            p2    <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= MUL;
          end
        end
        MUL: begin
          p0  <= p0_n;
          p1  <= p1_n;
          p2  <= p2_n;
          am  <= am >> DIGIT;
          bm  <= bm >> DIGIT;
          sm  <= sm >> DIGIT;
          cm  <= cm << DIGIT;
          dm  <= dm << DIGIT;
          tm  <= tm << DIGIT;
          cnt <= cnt + 1'b1;
          if (cnt == KL) state <= COMB;
        end
        COMB: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  // Result register plus PIPE delay stages; data holds until a new tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= PIPE; k++) begin
        pd[k] <= '0;
        pv[k] <= 1'b0;
      end
    end else begin
      pv[0] <= ld;
      if (ld) pd[0] <= r;
      for (int k = 1; k <= PIPE; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) pd[k] <= pd[k-1];
      end
    end
  end

  assign c     = pd[PIPE];
  assign valid = pv[PIPE];

endmodule

// File: tb/tb_two_way_karatsuba_iter.sv
// Bench for two_way_karatsuba_iter: directed timing cases plus
// randomized streams checked against a plain carry-less product model.
module tb_two_way_karatsuba_iter;

  logic clk;
  logic rst;

  logic         start8, ready8, valid8;
  logic [7:0]   a8, b8;
  logic [15:0]  c8;

  logic         start7, ready7, valid7;
  logic [6:0]   a7, b7;
  logic [13:0]  c7;

  logic         start16, ready16, valid16;
  logic [15:0]  a16, b16;
  logic [31:0]  c16;

  logic         startd, readyd, validd;
  logic [282:0] ad, bd;
  logic [565:0] cd;

  int nvec = 0;
  int nerr = 0;

  two_way_karatsuba_iter #(.N(8), .DIGIT(1), .PIPE(0)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .valid(valid8), .c(c8)
  );

  two_way_karatsuba_iter #(.N(7), .DIGIT(2), .PIPE(1)) u7 (
    .clk(clk), .rst(rst), .start(start7), .a(a7), .b(b7),
    .ready(ready7), .valid(valid7), .c(c7)
  );

  two_way_karatsuba_iter #(.N(16), .DIGIT(3), .PIPE(0)) u16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .valid(valid16), .c(c16)
  );

  two_way_karatsuba_iter ud (
    .clk(clk), .rst(rst), .start(startd), .a(ad), .b(bd),
    .ready(readyd), .valid(validd), .c(cd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [565:0] clmul(input logic [282:0] x,
                                         input logic [282:0] y);
    logic [565:0] acc;
    acc = '0;
    for (int i = 0; i < 283; i++)
      if (y[i]) acc = acc ^ (566'(x) << i);
    return acc;
  endfunction

  function automatic logic [282:0] rnd283();
    logic [282:0] v;
    v = '0;
    for (int w = 0; w < 9; w++) v = {v[250:0], 32'($urandom)};
    return v;
  endfunction

  task automatic chk(input string tag, input logic [565:0] obs,
                     input logic [565:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on the N=8 (sel 8) or N=7 (sel 7) instance, watched
  // cycle by cycle; optional busy re-start and mid-run reset offsets.
  task automatic single(input int sel, input logic [15:0] x,
                        input logic [15:0] y, input logic [565:0] e,
                        input int busy_at, input int rst_at);
    int lat, kk;
    logic post, er, ev, v, rd, s;
    logic [565:0] cc;
    logic [15:0] xa, ya;
    lat = (sel == 8) ? 6 : 5;
    kk  = (sel == 8) ? 4 : 2;
    for (int o = 0; o <= lat + 4; o++) begin
      v  = (sel == 8) ? valid8 : valid7;
      rd = (sel == 8) ? ready8 : ready7;
      cc = (sel == 8) ? 566'(c8) : 566'(c7);
      if (o == 0) begin
        chk("accept_ready", 566'(rd), 566'(1'b1));
      end else begin
        post = (rst_at >= 0) && (o > rst_at);
        er = post ? 1'b1 : !(o <= kk + 1);
        ev = post ? 1'b0 : (o == lat);
        chk("ready", 566'(rd), 566'(er));
        chk("valid", 566'(v), 566'(ev));
        if (post) chk("c_after_rst", cc, '0);
        else if (o >= lat) chk("c", cc, e);
      end
      s  = (o == 0) || (o == busy_at);
      xa = (o == 0) ? x : 16'($urandom);
      ya = (o == 0) ? y : 16'($urandom);
      rst = (o == rst_at);
      if (sel == 8) begin
        start8 = s; a8 = xa[7:0]; b8 = ya[7:0];
      end else begin
        start7 = s; a7 = xa[6:0]; b7 = ya[6:0];
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    start7 = 1'b0;
  endtask

  // Start held high with operands changing every cycle; accepts land
  // every K+2 cycles and results must come out in order.
  task automatic stream(input int sel, input int nops);
    int per, lat, acc;
    int tq[$];
    logic [565:0] eq[$];
    logic [282:0] x, y, m;
    logic [565:0] cc;
    logic v, rd, s, due;
    per = sel ? 144 : 5;
    lat = sel ? 146 : 5;
    m   = sel ? '1 : 283'hFFFF;
    acc = 0;
    for (int o = 0; o < nops * per + lat + 2; o++) begin
      v  = sel ? validd : valid16;
      rd = sel ? readyd : ready16;
      cc = sel ? cd : 566'(c16);
      due = (tq.size() > 0) && (tq[0] == o);
      chk("strm_valid", 566'(v), 566'(due));
      if (due) begin
        chk("strm_c", cc, eq[0]);
        void'(tq.pop_front());
        void'(eq.pop_front());
      end
      x = rnd283() & m;
      y = rnd283() & m;
      s = 1'b0;
      if (acc < nops) begin
        s = 1'b1;
        if (o == acc * per) begin
          chk("strm_ready", 566'(rd), 566'(1'b1));
          if (sel == 0 && acc == 0) begin
            x = 283'h8001;
            y = 283'h8001;
            eq.push_back(566'h40000001);
          end else begin
            eq.push_back(clmul(x, y));
          end
          tq.push_back(o + lat);
          acc++;
        end
      end
      if (sel != 0) begin
        startd = s; ad = x; bd = y;
      end else begin
        start16 = s; a16 = x[15:0]; b16 = y[15:0];
      end
      @(negedge clk);
    end
    start16 = 1'b0;
    startd  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start7 = 1'b0; a7 = '0; b7 = '0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    startd = 1'b0; ad = '0; bd = '0;
    repeat (2) @(negedge clk);

    chk("rst_ready8", 566'(ready8), 566'(1'b1));
    chk("rst_valid8", 566'(valid8), '0);
    chk("rst_c8", 566'(c8), '0);
    chk("rst_ready7", 566'(ready7), 566'(1'b1));
    chk("rst_valid7", 566'(valid7), '0);
    chk("rst_c7", 566'(c7), '0);
    chk("rst_ready16", 566'(ready16), 566'(1'b1));
    chk("rst_valid16", 566'(valid16), '0);
    chk("rst_c16", 566'(c16), '0);
    chk("rst_readyd", 566'(readyd), 566'(1'b1));
    chk("rst_validd", 566'(validd), '0);
    chk("rst_cd", cd, '0);

    rst = 1'b0;
    @(negedge clk);

    single(8, 16'h03, 16'h03, 566'h0005, -1, -1);
    single(8, 16'hFF, 16'hFF, 566'h5555, -1, -1);
    single(8, 16'h01, 16'hB7, 566'h00B7, -1, -1);
    single(8, 16'h00, 16'hFF, 566'h0000, -1, -1);
    single(8, 16'hA5, 16'h3C, clmul(283'hA5, 283'h3C), 2, -1);
    single(8, 16'h5A, 16'hC3, clmul(283'h5A, 283'hC3), 2, 3);
    single(7, 16'h7F, 16'h7F, 566'h1555, -1, -1);
    single(7, 16'h40, 16'h40, 566'h1000, -1, -1);

    stream(0, 8);
    stream(1, 150);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
